// File: rtl/latrsnq_stim_checker.sv
// Pin-level driver and checker for one active-low set/reset enable latch cell.
// Sequences E/D/RN/SETN with programmable spacing and checks synchronized Q against a shadow.
module latrsnq_stim_checker #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned WIDTH_CYC   = 3,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned RECOV_CYC   = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_d,
    output logic       lat_e,
    output logic       lat_d,
    output logic       lat_rn,
    output logic       lat_setn,
    input  logic       lat_q,
    output logic       rsp_valid,
    output logic       rsp_q,
    output logic       rsp_err,
    output logic [7:0] err_cnt,
    output logic       busy
);

    typedef enum logic [1:0] {OpWrite = 2'b00, OpClear = 2'b01, OpPreset = 2'b10,
                              OpRead = 2'b11} op_e;

    typedef enum logic [2:0] {StIdle, StLaunch, StSetup, StPulse, StHold, StRecov,
                              StCheck} state_e;

    localparam logic [7:0] SetupLd = 8'(SETUP_CYC - 1);
    localparam logic [7:0] WidthLd = 8'(WIDTH_CYC - 1);
    localparam logic [7:0] HoldLd  = 8'(HOLD_CYC - 1);
    localparam logic [7:0] RecovLd = 8'(RECOV_CYC - 1);
    localparam logic [7:0] SyncLd  = 8'(SYNC_STAGES - 1);
    // One extra count after reset: the first edge only releases lat_rn.
    localparam logic [7:0] BootLd  = 8'(RECOV_CYC);

    state_e                 state_q;
    op_e                    op_q;
    logic [7:0]             cnt_q;
    logic                   d_q;
    logic                   boot_q;
    logic                   shadow_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   expected;
    logic                   done;

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign done      = (cnt_q == 8'd0);
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);

    always_comb begin
        expected = shadow_q;
        unique case (op_q)
            OpWrite:  expected = d_q;
            OpClear:  expected = 1'b0;
            OpPreset: expected = 1'b1;
            OpRead:   expected = shadow_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lat_q};
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= StRecov;
            op_q      <= OpRead;
            cnt_q     <= BootLd;
            d_q       <= 1'b0;
            boot_q    <= 1'b1;
            shadow_q  <= 1'b0;
            lat_e     <= 1'b0;
            lat_d     <= 1'b0;
            lat_rn    <= 1'b0;
            lat_setn  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_q     <= 1'b0;
            rsp_err   <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q    <= op_e'(cmd_op);
                        d_q     <= cmd_d;
                        state_q <= StLaunch;
                    end
                end
                StLaunch: begin
                    unique case (op_q)
                        OpWrite: begin
                            state_q <= StSetup;
                            cnt_q   <= SetupLd;
                            lat_d   <= d_q;
                        end
                        OpClear: begin
                            state_q <= StPulse;
                            cnt_q   <= WidthLd;
                            lat_rn  <= 1'b0;
                        end
                        OpPreset: begin
                            state_q  <= StPulse;
                            cnt_q    <= WidthLd;
                            lat_setn <= 1'b0;
                        end
                        OpRead: begin
                            state_q <= StCheck;
                            cnt_q   <= SyncLd;
                        end
                    endcase
                end
                StSetup: begin
                    if (done) begin
                        state_q <= StPulse;
                        cnt_q   <= WidthLd;
                        lat_e   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StPulse: begin
                    if (done) begin
                        lat_e    <= 1'b0;
                        lat_rn   <= 1'b1;
                        lat_setn <= 1'b1;
                        state_q  <= (op_q == OpWrite) ? StHold : StRecov;
                        cnt_q    <= (op_q == OpWrite) ? HoldLd : RecovLd;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StHold: begin
                    if (done) begin
                        state_q <= StCheck;
                        cnt_q   <= SyncLd;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StRecov: begin
                    lat_rn <= 1'b1;
                    if (done) begin
                        boot_q  <= 1'b0;
                        state_q <= boot_q ? StIdle : StCheck;
                        cnt_q   <= SyncLd;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StCheck: begin
                    if (done) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b1;
                        rsp_q     <= sync_out;
                        rsp_err   <= (sync_out != expected);
                        shadow_q  <= expected;
                        if ((sync_out != expected) && (err_cnt != 8'hff)) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_latrsnq_stim_checker.sv
// Directed bench for latrsnq_stim_checker driving a behavioural set/reset latch model.
module tb_latrsnq_stim_checker;

    logic       clk = 1'b0;
    logic       rn = 1'b0;
    logic       cmd_valid, cmd_ready, cmd_d;
    logic [1:0] cmd_op;
    logic       lat_e, lat_d, lat_rn, lat_setn, lat_q;
    logic       rsp_valid, rsp_q, rsp_err, busy;
    logic [7:0] err_cnt;
    logic       stuck = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] OP_WRITE = 2'b00, OP_CLEAR = 2'b01, OP_PRESET = 2'b10,
                           OP_READ = 2'b11;

    latrsnq_stim_checker dut (
        .CLK       (clk),
        .RN        (rn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_d     (cmd_d),
        .lat_e     (lat_e),
        .lat_d     (lat_d),
        .lat_rn    (lat_rn),
        .lat_setn  (lat_setn),
        .lat_q     (lat_q),
        .rsp_valid (rsp_valid),
        .rsp_q     (rsp_q),
        .rsp_err   (rsp_err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Latch cell: RN dominates, then SETN, transparent while E high, else holds.
    always @* begin
        if (stuck) lat_q = 1'b0;
        else if (!lat_rn) lat_q = 1'b0;
        else if (!lat_setn) lat_q = 1'b1;
        else if (lat_e) lat_q = lat_d;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one command; k counts edges after the accepting edge.
    task automatic run_cmd(input logic [1:0] op, input logic d, output int lat,
                           output logic q, output logic err, output logic [31:0] e_m,
                           output logic [31:0] rn_m, output logic [31:0] setn_m);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick;
            w++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_d     = d;
        tick;
        cmd_valid = 1'b0;
        lat = 0; q = 1'b0; err = 1'b0; e_m = '0; rn_m = '0; setn_m = '0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (k < 32) begin
                e_m[k]    = lat_e;
                rn_m[k]   = ~lat_rn;
                setn_m[k] = ~lat_setn;
            end
            if (rsp_valid) begin
                lat = k;
                q   = rsp_q;
                err = rsp_err;
                break;
            end
        end
    endtask

    int          lat, pulses, bad_err;
    logic        q, err;
    logic [31:0] em, rm, sm;

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_d     = 1'b0;
        repeat (3) tick;
        check_eq("rst_lat_rn", lat_rn, 0);
        check_eq("rst_lat_setn", lat_setn, 1);
        check_eq("rst_lat_e", lat_e, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_ready", cmd_ready, 0);
        check_eq("rst_rsp", {rsp_valid, rsp_q, rsp_err}, 0);
        check_eq("rst_err_cnt", err_cnt, 0);

        rn = 1'b1;
        tick;
        check_eq("boot_rn_edge1", lat_rn, 1);
        check_eq("boot_ready_edge1", cmd_ready, 0);
        tick;
        check_eq("boot_ready_edge2", cmd_ready, 0);
        tick;
        check_eq("boot_ready_edge3", cmd_ready, 1);

        run_cmd(OP_READ, 1'b0, lat, q, err, em, rm, sm);
        check_eq("read0_lat", lat, 3);
        check_eq("read0_q", q, 0);
        check_eq("read0_err", err, 0);
        tick;
        check_eq("rsp_one_cycle", rsp_valid, 0);

        run_cmd(OP_WRITE, 1'b1, lat, q, err, em, rm, sm);
        check_eq("write1_e_mask", em, 32'h0000_0038);
        check_eq("write1_lat", lat, 10);
        check_eq("write1_q", q, 1);
        check_eq("write1_err", err, 0);
        check_eq("write1_lat_d_held", lat_d, 1);
        run_cmd(OP_READ, 1'b0, lat, q, err, em, rm, sm);
        check_eq("read1_lat", lat, 3);
        check_eq("read1_q", q, 1);

        run_cmd(OP_PRESET, 1'b0, lat, q, err, em, rm, sm);
        check_eq("preset_setn_mask", sm, 32'h0000_000e);
        check_eq("preset_rn_mask", rm, 0);
        check_eq("preset_lat", lat, 8);
        check_eq("preset_q", {q, err}, 2'b10);
        run_cmd(OP_CLEAR, 1'b0, lat, q, err, em, rm, sm);
        check_eq("clear_rn_mask", rm, 32'h0000_000e);
        check_eq("clear_setn_mask", sm, 0);
        check_eq("clear_lat", lat, 8);
        check_eq("clear_q", {q, err}, 2'b00);
        check_eq("err_cnt_clean", err_cnt, 0);

        // cmd_valid held through a WRITE; a READ sits behind it.
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_d     = 1'b1;
        tick;
        cmd_op = OP_READ;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            tick;
            if (rsp_valid) pulses++;
            if (k == 9) check_eq("held_busy9", busy, 1);
        end
        check_eq("held_rsp10", rsp_valid, 1);
        check_eq("held_ready10", cmd_ready, 1);
        tick;
        cmd_valid = 1'b0;
        check_eq("held_accept11", busy, 1);
        if (rsp_valid) pulses++;
        for (int k = 12; k <= 14; k++) begin
            tick;
            if (rsp_valid) pulses++;
        end
        check_eq("held_read_rsp14", {rsp_valid, rsp_q, rsp_err}, 3'b110);
        repeat (3) begin
            tick;
            if (rsp_valid) pulses++;
        end
        check_eq("held_pulses", pulses, 2);

        // Reset during the E pulse of a WRITE.
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_d     = 1'b1;
        tick;
        cmd_valid = 1'b0;
        repeat (4) tick;
        check_eq("abort_e_before", lat_e, 1);
        rn = 1'b0;
        #1;
        check_eq("abort_e", lat_e, 0);
        check_eq("abort_rn", lat_rn, 0);
        pulses = 0;
        repeat (12) begin
            tick;
            if (rsp_valid) pulses++;
        end
        check_eq("abort_no_rsp", pulses, 0);
        rn = 1'b1;
        run_cmd(OP_READ, 1'b0, lat, q, err, em, rm, sm);
        check_eq("abort_read_lat", lat, 3);
        check_eq("abort_read_q", {q, err}, 2'b00);

        // Stuck-at-0 cell: every WRITE 1 mismatches.
        stuck   = 1'b1;
        bad_err = 0;
        for (int i = 0; i < 300; i++) begin
            run_cmd(OP_WRITE, 1'b1, lat, q, err, em, rm, sm);
            if (err !== 1'b1 || q !== 1'b0 || lat != 10) bad_err++;
            if (i == 0) check_eq("stuck_err_cnt1", err_cnt, 1);
        end
        check_eq("stuck_all_err", bad_err, 0);
        check_eq("stuck_err_cnt_sat", err_cnt, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
